phi_gen: RTL and testbench
==========================

PHI_GEN -- requirements
Module: phi_gen

Interface
REQ-001 Parameter DIV_W, default 8, width of the half-period divisor and down-counter.
REQ-002 Parameter CNT_W, default 16, width of the completed-cycle counter.
REQ-003 CLOCK_50  input  1  sole clock; all logic on its rising edge.
REQ-004 res  input  1  reset, synchronous, active-high.
REQ-005 div  input  DIV_W  half-period divisor; half period = div+1 CLOCK_50 cycles.
REQ-006 run  input  1  level; 1 = free-running, 0 = halt at end of current phi cycle.
REQ-007 step_req  input  1  level, already debounced; its rising edge requests one phi cycle while halted.
REQ-008 phi  output  1  registered CPU clock.
REQ-009 phi1_en  output  1  one-cycle strobe, high in the same cycle phi first reads 1.
REQ-010 phi2_en  output  1  one-cycle strobe, high in the same cycle phi first reads 0.
REQ-011 halted  output  1  high while in HALT.
REQ-012 cycle_cnt  output  CNT_W  count of phi rising edges.

Function
REQ-013 States: HALT, RUN, STEP.
REQ-014 Down-counter cnt (DIV_W bits): in RUN/STEP, if cnt==0 then phi toggles and cnt reloads from div, else cnt decrements.
REQ-015 div is sampled only at a reload or on HALT exit; changes mid-half-period do not affect the current half.
REQ-016 div==0: phi toggles every CLOCK_50 cycle, period 2 clocks.
REQ-017 phi1_en and phi2_en are registered alongside phi and are never high together.
REQ-018 HALT -> RUN when run==1: cnt loads div, phi stays 0; first phi rise occurs div+1 clocks after the transition cycle.
REQ-019 RUN -> HALT: run==0 is sampled at each phi fall; if 0 there, state becomes HALT in that cycle with phi=0; a high half in progress always completes.
REQ-020 HALT -> STEP on step_req rising edge with run==0: cnt loads div; exactly one full phi cycle (high half, low half) follows, then HALT at the phi fall.
REQ-021 In STEP, further step_req edges are ignored, not queued; run==1 during STEP transitions to RUN at the step's phi fall.
REQ-022 run==1 and a step_req edge together in HALT: RUN wins; the edge is discarded.
REQ-023 cycle_cnt increments by 1 on each phi rise, wrapping from all-ones to 0.
REQ-024 halted is high exactly when state is HALT; phi is 0 whenever halted is high.

Reset
REQ-025 While res==1: state=HALT, phi=0, phi1_en=0, phi2_en=0, cnt=0, cycle_cnt=0, step edge-detector history=1 (a step_req held high across reset does not trigger a step).
REQ-026 res asserted mid-half-period aborts the half immediately; there is no clean-up cycle.

Configuration
REQ-027 Macro PHI_GEN_STEP_EN: when defined, STEP state and step_req edge detection are built as in REQ-020..022.
REQ-028 Without PHI_GEN_STEP_EN: STEP state is absent, step_req is ignored (port kept), and HALT exits only via run.

Structure
REQ-029 Package phi_gen_pkg holds the state enum typedef (HALT, RUN, STEP) and default DIV_W/CNT_W constants.
REQ-030 Sub-module rise_det (1-bit registered rising-edge detector with reset value parameter) is used for step_req.

Verification
REQ-031 res 1 -> 0, run=1, div=3 -> first phi rise 4 clocks after the HALT->RUN cycle, then 4-high/4-low, phi1_en/phi2_en single pulses at each edge.
REQ-032 div=0, run=1 for 20 clocks -> phi toggles every clock, cycle_cnt=10 after exactly 10 rises.
REQ-033 div=5, run dropped 2 clocks into a high half -> high half finishes (6 clocks), halted rises with the phi fall, phi held 0.
REQ-034 Halted, div=2, step_req pulses twice 2 clocks apart -> exactly one phi cycle (3 high, 3 low), cycle_cnt +1, back in HALT; with PHI_GEN_STEP_EN undefined -> no phi activity.
REQ-035 CNT_W=4, 16 rises -> cycle_cnt wraps 15 -> 0.
REQ-036 res pulsed mid-high-half with step_req held 1 -> all outputs 0, halted=1, no step after reset releases.

Source files
------------

// File: rtl/phi_gen_pkg.sv
// Shared types and default widths for the phi_gen CPU clock generator.
package phi_gen_pkg;

    typedef enum logic [1:0] {
        HALT,
        RUN,
        STEP
    } state_e;

    localparam int DIV_W_DEF = 8;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/phi_gen_rise_det.sv
// Rising-edge detector: the history register resets to RST_VAL so a level
// already high when reset releases is not mistaken for a new edge.
module rise_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/phi_gen.sv
// Two-phase CPU clock generator with run/halt control and a completed-cycle
// counter. Define PHI_GEN_STEP_EN to build single-step support on step_req.
module phi_gen
    import phi_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLOCK_50,
    input  logic             res,
    input  logic [DIV_W-1:0] div,
    input  logic             run,
    input  logic             step_req,
    output logic             phi,
    output logic             phi1_en,
    output logic             phi2_en,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               phi_q, phi_d;
    logic               phi1_q, phi1_d;
    logic               phi2_q, phi2_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;

`ifdef PHI_GEN_STEP_EN
    logic step_rise;

    rise_det #(
        .RST_VAL(1'b1)
    ) u_step_det (
        .clk_i (CLOCK_50),
        .rst_i (res),
        .d_i   (step_req),
        .rise_o(step_rise)
    );
`else
    logic unused_step_req;
    assign unused_step_req = step_req;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (res) begin
            state_q <= HALT;
            cnt_q   <= '0;
            phi_q   <= 1'b0;
            phi1_q  <= 1'b0;
            phi2_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            phi1_q  <= phi1_d;
            phi2_q  <= phi2_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        phi1_d  = 1'b0;
        phi2_d  = 1'b0;
        cyc_d   = cyc_q;
        unique case (state_q)
            HALT: begin
                phi_d = 1'b0;
                // run takes priority; a simultaneous step edge is consumed and lost
                if (run) begin
                    state_d = RUN;
                    cnt_d   = div;
                end
`ifdef PHI_GEN_STEP_EN
                else if (step_rise) begin
                    state_d = STEP;
                    cnt_d   = div;
                end
`endif
            end
            default: begin
                if (cnt_q == '0) begin
                    cnt_d = div;
                    phi_d = ~phi_q;
                    if (!phi_q) begin
                        phi1_d = 1'b1;
                        cyc_d  = cyc_q + 1'b1;
                    end else begin
                        // run is only honoured at a phi fall, so a high half always completes
                        phi2_d  = 1'b1;
                        state_d = run ? RUN : HALT;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    assign phi       = phi_q;
    assign phi1_en   = phi1_q;
    assign phi2_en   = phi2_q;
    assign halted    = (state_q == HALT);
    assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_phi_gen.sv
// Scoreboard bench for phi_gen: a half-period reference model predicts every
// cycle's outputs; a monitor compares two instances (16-bit and 4-bit counter).
module tb_phi_gen;

`ifdef PHI_GEN_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [7:0] div = 8'd3;
    logic       run = 1'b0;
    logic       step_req = 1'b0;

    logic        phi, phi1_en, phi2_en, halted;
    logic [15:0] cycle_cnt;
    logic        phi_b, phi1_b, phi2_b, halted_b;
    logic [3:0]  cycle_cnt_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    phi_gen #(.DIV_W(8), .CNT_W(16)) dut (
        .CLOCK_50 (clk),
        .res      (res),
        .div      (div),
        .run      (run),
        .step_req (step_req),
        .phi      (phi),
        .phi1_en  (phi1_en),
        .phi2_en  (phi2_en),
        .halted   (halted),
        .cycle_cnt(cycle_cnt)
    );

    phi_gen #(.DIV_W(8), .CNT_W(4)) dut_w4 (
        .CLOCK_50 (clk),
        .res      (res),
        .div      (div),
        .run      (run),
        .step_req (step_req),
        .phi      (phi_b),
        .phi1_en  (phi1_b),
        .phi2_en  (phi2_b),
        .halted   (halted_b),
        .cycle_cnt(cycle_cnt_b)
    );

    typedef struct {
        logic        phi;
        logic        p1;
        logic        p2;
        logic        h;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];

    // Reference model: elapsed clocks within the current half vs. its length.
    bit          m_halted = 1'b1;
    bit          m_phi    = 1'b0;
    bit          m_prev   = 1'b1;
    int          m_len    = 0;
    int          m_el     = 0;
    logic [31:0] m_cyc    = '0;

    always @(posedge clk) begin
        exp_t e;
        bit   s1, s2, edge_seen;
        s1 = 1'b0;
        s2 = 1'b0;
        if (res) begin
            m_halted = 1'b1;
            m_phi    = 1'b0;
            m_prev   = 1'b1;
            m_el     = 0;
            m_cyc    = '0;
        end else begin
            edge_seen = step_req && !m_prev;
            m_prev    = step_req;
            if (m_halted) begin
                if (run || (STEP_EN && edge_seen)) begin
                    m_halted = 1'b0;
                    m_len    = int'(div) + 1;
                    m_el     = 0;
                end
            end else begin
                m_el = m_el + 1;
                if (m_el == m_len) begin
                    m_el  = 0;
                    m_len = int'(div) + 1;
                    if (!m_phi) begin
                        m_phi = 1'b1;
                        s1    = 1'b1;
                        m_cyc = m_cyc + 1;
                    end else begin
                        m_phi = 1'b0;
                        s2    = 1'b1;
                        if (!run) m_halted = 1'b1;
                    end
                end
            end
        end
        e.phi = m_phi;
        e.p1  = s1;
        e.p2  = s2;
        e.h   = m_halted;
        e.cyc = m_cyc;
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        n_chk = n_chk + 1;
        if (sb.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_empty at %0t: no expected entry for observed outputs", $time);
        end else begin
            e = sb.pop_front();
            if (phi !== e.phi || phi1_en !== e.p1 || phi2_en !== e.p2 || halted !== e.h ||
                cycle_cnt !== e.cyc[15:0] || phi_b !== e.phi || phi1_b !== e.p1 ||
                phi2_b !== e.p2 || halted_b !== e.h || cycle_cnt_b !== e.cyc[3:0]) begin
                n_fail = n_fail + 1;
                $display("FAIL outputs at %0t: got phi/p1/p2/halt=%b%b%b%b cnt16=%0d | w4 %b%b%b%b cnt4=%0d ; want %b%b%b%b cnt16=%0d cnt4=%0d",
                         $time, phi, phi1_en, phi2_en, halted, cycle_cnt,
                         phi_b, phi1_b, phi2_b, halted_b, cycle_cnt_b,
                         e.phi, e.p1, e.p2, e.h, e.cyc[15:0], e.cyc[3:0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rise(input int budget);
        int k;
        k = 0;
        while (!phi1_en && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_chk = n_chk + 1;
        if (!phi1_en) begin
            n_fail = n_fail + 1;
            $display("FAIL wait_phi_rise: phi1_en=%b after %0d clocks, want 1", phi1_en, budget);
        end
    endtask

    initial begin
        // Reset, then free-run at div=3
        tick(3);
        res = 1'b0;
        run = 1'b1;
        tick(40);

        // div=0 full-speed run, long enough to wrap the 4-bit counter too
        div = 8'd0;
        tick(20);
        tick(30);

        // Drop run two clocks into a div=5 high half
        div = 8'd5;
        tick(8);
        wait_rise(40);
        tick(2);
        run = 1'b0;
        tick(20);

        // Two step_req pulses while halted
        div = 8'd2;
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        tick(1);
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        tick(14);

        // run and step edge together while halted
        step_req = 1'b1;
        run = 1'b1;
        tick(12);
        run = 1'b0;
        step_req = 1'b0;
        tick(12);

        // Reset mid-high-half with step_req held high across it
        run = 1'b1;
        div = 8'd4;
        wait_rise(40);
        tick(1);
        step_req = 1'b1;
        tick(1);
        res = 1'b1;
        run = 1'b0;
        tick(2);
        res = 1'b0;
        tick(15);
        step_req = 1'b0;
        tick(3);

        // Randomised control traffic
        for (int i = 0; i < 600; i++) begin
            res = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 6) run = ~run;
            if ($urandom_range(0, 99) < 10) div = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 99) < 15) step_req = ~step_req;
            tick(1);
        end
        res = 1'b0;
        run = 1'b0;
        tick(20);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
